map_cyc_irq: RTL and testbench
==============================

MAP_CYC_IRQ -- requirements
Module: map_cyc_irq

Interface
REQ-001 The block SHALL have parameter CH, default 2, the number of independent timer channels (1..4).
REQ-002 The block SHALL have parameter W, default 16, the counter and reload width in bits (8..24).
REQ-003 The block SHALL have port m2, input, 1 bit: the CPU M2 clock; all state changes SHALL occur on its falling edge.
REQ-004 The block SHALL have port map_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port reg_we, input, 1 bit: register write strobe, sampled on the m2 falling edge.
REQ-006 The block SHALL have port reg_addr, input, 5 bits: bits [4:3] select the channel and bits [2:0] select the register.
REQ-007 The block SHALL have port reg_di, input, 8 bits: write data.
REQ-008 The block SHALL have port reg_do, output, 8 bits: combinational readback.
REQ-009 The block SHALL have port irq_pend, output, CH bits: per-channel pending flags.
REQ-010 The block SHALL have port irq, output, 1 bit: the OR of irq_pend.

Function
REQ-011 The per-channel register map SHALL be:
- 0/1/2: reload bytes [7:0], [15:8], [23:16]; bits at or above W are ignored.
- 3: ctrl; bit0 = en, bit1 = auto, bit2 = stop_on_pend.
- 4: reload strobe.
- 5: acknowledge.
- 6/7: not writable.
REQ-012 A write SHALL occur only when reg_we=1 and the channel index is below CH; writes to an absent channel SHALL be ignored.
REQ-013 A write to ctrl SHALL update en, auto and stop_on_pend, and SHALL clear that channel's pend.
REQ-014 A write to register 4 SHALL set reload_req; on the next falling edge the channel SHALL load ctr from reload, clear pend and clear reload_req, and SHALL NOT decrement on that edge.
REQ-015 A write to register 5 SHALL clear pend and leave all other state unchanged.
REQ-016 On every edge with en=1 and no reload_req, the channel SHALL do the following:
- If ctr = 1: set pend; the next ctr is reload when auto=1, else 0.
- If ctr > 1: decrement ctr by 1.
- If ctr = 0: hold ctr and do not set pend.
REQ-017 When stop_on_pend=1 and pend=1, the channel SHALL hold ctr until pend is cleared.
REQ-018 With auto=1 and reload=0, the channel SHALL reach 0 and stop; no further pend is raised.
REQ-019 Counter arithmetic SHALL be W bits, unsigned, with no wrap below 0.
REQ-020 Register writes SHALL take effect after the edge that samples them; counting on that same edge SHALL use the pre-write en, auto, stop_on_pend and reload values.
REQ-021 If a pend set (ctr = 1) and a pend clear (ctrl write or acknowledge) hit the same channel on the same edge, the set SHALL win.
REQ-022 If a reload-byte write and a pending reload_req load occur on the same edge, the old reload value SHALL be loaded.
REQ-023 reg_do SHALL be combinational and SHALL return:
- Registers 0..2: reload bytes.
- Register 3: {5'b0, stop_on_pend, auto, en}.
- Register 4: {7'b0, pend}.
- Register 5: {7'b0, reload_req}.
- Register 6: ctr[7:0].
- Register 7: ctr[15:8].
- Absent channel, or bytes at or above W: 8'hFF.
REQ-024 Channels SHALL be fully independent; simultaneous events on different channels SHALL NOT interact.
REQ-025 irq SHALL have zero latency from irq_pend: both are purely combinational from the registered pend flags.

Reset
REQ-026 When map_rst_n=0, for every channel the block SHALL immediately clear ctr, reload, en, auto, stop_on_pend, pend and reload_req to 0, without waiting for m2.
REQ-027 While map_rst_n=0, irq SHALL be 0, irq_pend SHALL be 0, and reg_do SHALL reflect the cleared registers.
REQ-028 Reset asserted mid-count SHALL abort the count with no residual pend.
REQ-029 After reset release, no counting SHALL occur until ctrl en=1 is written.

Verification
REQ-030 Ch0 one-shot:
- Stimulus: reload=0x0003, strobe, then ctrl=0x01.
- Response: ctr reads 3, 2, 1, 0 on successive edges; irq rises on the edge where ctr leaves 1 and stays high; ctr holds at 0.
REQ-031 Ch1 auto-reload:
- Stimulus: reload=0x0002, ctrl=0x03, strobe.
- Response: pend is set every 2 edges; ack clears it; the ack/set collision on the same edge leaves pend=1.
REQ-032 stop_on_pend:
- Stimulus: ch0 reload=0x0002, ctrl=0x07, run to pend, hold 10 edges, then ack.
- Response: ctr frozen at 2 during the hold; counting resumes on the edge after the ack.
REQ-033 Reload collision:
- Stimulus: strobe on one edge, then write reload[7:0]=0x55 on the next edge while the old reload is 0x10.
- Response: ctr=0x10, then reload reads 0x55.
REQ-034 Reset mid-operation:
- Stimulus: ch0 counting with irq=1; pulse map_rst_n low between m2 edges.
- Response: irq=0 immediately; all readbacks are 0 except absent and out-of-width bytes, which read 0xFF.
REQ-035 Width/channel params:
- Stimulus: CH=1, W=24; write ch1 ctrl=0x01; write reload[23:16]=0x01, strobe.
- Response: ch1 writes are ignored and read 0xFF; ctr=0x010000 and decrements to 0x00FFFF.

Source files
------------

// File: rtl/map_cyc_irq.sv
`timescale 1ns/1ps
// map_cyc_irq: CH independent down-counting timers clocked on the M2 falling edge. Each channel
// has a byte-wide reload, control, reload strobe, acknowledge and a pending flag feeding irq.
module map_cyc_irq #(
    parameter int CH = 2,
    parameter int W  = 16
) (
    input  logic          m2,
    input  logic          map_rst_n,
    input  logic          reg_we,
    input  logic [4:0]    reg_addr,
    input  logic [7:0]    reg_di,
    output logic [7:0]    reg_do,
    output logic [CH-1:0] irq_pend,
    output logic          irq
);

    localparam logic [2:0] R_RLD0   = 3'd0;
    localparam logic [2:0] R_RLD1   = 3'd1;
    localparam logic [2:0] R_RLD2   = 3'd2;
    localparam logic [2:0] R_CTRL   = 3'd3;
    localparam logic [2:0] R_STROBE = 3'd4;
    localparam logic [2:0] R_ACK    = 3'd5;
    localparam logic [2:0] R_CTR_LO = 3'd6;

    logic          ch_ok;
    logic [W-1:0]  reload_v [CH];
    logic [W-1:0]  ctr_v    [CH];
    logic [CH-1:0] en_v;
    logic [CH-1:0] auto_v;
    logic [CH-1:0] sop_v;
    logic [CH-1:0] req_v;

    assign ch_ok = ({1'b0, reg_addr[4:3]} < 3'(CH));

    // Byte idx of a W-bit value; bytes lying entirely at or above W read as all ones.
    function automatic logic [7:0] byte_sel(input logic [W-1:0] v, input int idx);
        logic [7:0] b;
        b = 8'h00;
        if (idx * 8 >= W) begin
            return 8'hFF;
        end
        for (int k = 0; k < 8; k++) begin
            if (idx * 8 + k < W) begin
                b[k] = v[idx * 8 + k];
            end
        end
        return b;
    endfunction

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [W-1:0] reload;
        logic [W-1:0] reload_nx;
        logic [W-1:0] ctr;
        logic [W-1:0] ctr_next;
        logic         en;
        logic         auto_en;
        logic         stop_on_pend;
        logic         pend;
        logic         reload_req;
        logic         sel;
        logic         pend_set;
        logic         pend_clr;
        logic         req_next;

        assign sel = reg_we && ch_ok && (reg_addr[4:3] == 2'(i));

        always_comb begin
            reload_nx = reload;
            for (int b = 0; b < W; b++) begin
                if (sel && (reg_addr[2:0] == 3'(b / 8))) begin
                    reload_nx[b] = reg_di[b % 8];
                end
            end
        end

        // Counting sees only pre-edge state; a pend set from ctr=1 outranks any clear.
        always_comb begin
            ctr_next = ctr;
            pend_set = 1'b0;
            pend_clr = 1'b0;
            req_next = reload_req;
            if (reload_req) begin
                ctr_next = reload;
                pend_clr = 1'b1;
                req_next = 1'b0;
            end else if (en && !(stop_on_pend && pend)) begin
                if (ctr == W'(1)) begin
                    pend_set = 1'b1;
                    ctr_next = auto_en ? reload : '0;
                end else if (ctr != '0) begin
                    ctr_next = ctr - W'(1);
                end
            end
            if (sel && (reg_addr[2:0] == R_CTRL || reg_addr[2:0] == R_ACK)) begin
                pend_clr = 1'b1;
            end
            if (sel && reg_addr[2:0] == R_STROBE) begin
                req_next = 1'b1;
            end
        end

        always_ff @(negedge m2 or negedge map_rst_n) begin
            if (!map_rst_n) begin
                reload       <= '0;
                ctr          <= '0;
                en           <= 1'b0;
                auto_en      <= 1'b0;
                stop_on_pend <= 1'b0;
                pend         <= 1'b0;
                reload_req   <= 1'b0;
            end else begin
                reload     <= reload_nx;
                ctr        <= ctr_next;
                reload_req <= req_next;
                if (pend_set) begin
                    pend <= 1'b1;
                end else if (pend_clr) begin
                    pend <= 1'b0;
                end
                if (sel && reg_addr[2:0] == R_CTRL) begin
                    en           <= reg_di[0];
                    auto_en      <= reg_di[1];
                    stop_on_pend <= reg_di[2];
                end
            end
        end

        assign reload_v[i] = reload;
        assign ctr_v[i]    = ctr;
        assign en_v[i]     = en;
        assign auto_v[i]   = auto_en;
        assign sop_v[i]    = stop_on_pend;
        assign req_v[i]    = reload_req;
        assign irq_pend[i] = pend;
    end

    always_comb begin
        reg_do = 8'hFF;
        for (int i = 0; i < CH; i++) begin
            if (reg_addr[4:3] == 2'(i)) begin
                case (reg_addr[2:0])
                    R_RLD0:   reg_do = byte_sel(reload_v[i], 0);
                    R_RLD1:   reg_do = byte_sel(reload_v[i], 1);
                    R_RLD2:   reg_do = byte_sel(reload_v[i], 2);
                    R_CTRL:   reg_do = {5'b0, sop_v[i], auto_v[i], en_v[i]};
                    R_STROBE: reg_do = {7'b0, irq_pend[i]};
                    R_ACK:    reg_do = {7'b0, req_v[i]};
                    R_CTR_LO: reg_do = byte_sel(ctr_v[i], 0);
                    default:  reg_do = byte_sel(ctr_v[i], 1);
                endcase
            end
        end
    end

    assign irq = |irq_pend;

endmodule

// File: tb/tb_map_cyc_irq.sv
`timescale 1ns/1ps
// Bench for map_cyc_irq: a default instance (CH=2, W=16) and a CH=1, W=24 instance. Expected
// readbacks are queued alongside the stimulus and drained against reg_do between m2 edges.
module tb_map_cyc_irq;

    logic       m2 = 1'b1;
    logic       map_rst_n = 1'b1;

    logic       a_we = 1'b0;
    logic [4:0] a_addr = 5'd0;
    logic [7:0] a_di = 8'd0;
    logic [7:0] a_do;
    logic [1:0] a_pend;
    logic       a_irq;

    logic       b_we = 1'b0;
    logic [4:0] b_addr = 5'd0;
    logic [7:0] b_di = 8'd0;
    logic [7:0] b_do;
    logic [0:0] b_pend;
    logic       b_irq;

    int n_cmp = 0;
    int n_err = 0;

    string      q_tag  [$];
    bit         q_sel  [$];
    logic [4:0] q_addr [$];
    logic [7:0] q_exp  [$];

    map_cyc_irq #(.CH(2), .W(16)) dut_a (
        .m2(m2), .map_rst_n(map_rst_n), .reg_we(a_we), .reg_addr(a_addr),
        .reg_di(a_di), .reg_do(a_do), .irq_pend(a_pend), .irq(a_irq)
    );

    map_cyc_irq #(.CH(1), .W(24)) dut_b (
        .m2(m2), .map_rst_n(map_rst_n), .reg_we(b_we), .reg_addr(b_addr),
        .reg_di(b_di), .reg_do(b_do), .irq_pend(b_pend), .irq(b_irq)
    );

    always #50 m2 = ~m2;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One register write, sampled on the falling edge in the middle of this m2 period.
    task automatic applyStimulus(input bit sel_b, input logic [4:0] addr, input logic [7:0] data);
        if (sel_b) begin
            b_we = 1'b1; b_addr = addr; b_di = data;
        end else begin
            a_we = 1'b1; a_addr = addr; a_di = data;
        end
        @(posedge m2);
        a_we = 1'b0;
        b_we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge m2);
    endtask

    task automatic expectRead(input string tag, input bit sel_b, input logic [4:0] addr,
                              input logic [7:0] exp);
        q_tag.push_back(tag);
        q_sel.push_back(sel_b);
        q_addr.push_back(addr);
        q_exp.push_back(exp);
    endtask

    task automatic drainReads();
        string      tag;
        bit         sel_b;
        logic [4:0] addr;
        logic [7:0] exp;
        while (q_tag.size() > 0) begin
            tag = q_tag.pop_front();
            sel_b = q_sel.pop_front();
            addr = q_addr.pop_front();
            exp = q_exp.pop_front();
            if (sel_b) b_addr = addr; else a_addr = addr;
            #1;
            checkOutput(tag, sel_b ? b_do : a_do, exp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] start");
        #2 map_rst_n = 1'b0;
        #2;
        checkOutput("rst_irq", a_irq, 0);
        expectRead("rst_ctrl0", 0, 5'h03, 8'h00);
        expectRead("rst_rld2_w16", 0, 5'h02, 8'hFF);
        expectRead("rst_absent", 0, 5'h10, 8'hFF);
        expectRead("rst_ctr_hi", 0, 5'h07, 8'h00);
        expectRead("rst_b_rld2", 1, 5'h02, 8'h00);
        expectRead("rst_b_absent", 1, 5'h08, 8'hFF);
        drainReads();
        @(posedge m2);
        map_rst_n = 1'b1;

        // Ch0 one-shot from reload 3
        applyStimulus(0, 5'h00, 8'h03);
        applyStimulus(0, 5'h01, 8'h00);
        applyStimulus(0, 5'h04, 8'h01);
        applyStimulus(0, 5'h03, 8'h01);
        expectRead("os_ctr3", 0, 5'h06, 8'h03);
        expectRead("os_ctr3_hi", 0, 5'h07, 8'h00);
        expectRead("os_rld0", 0, 5'h00, 8'h03);
        expectRead("os_ctrl", 0, 5'h03, 8'h01);
        drainReads();
        checkOutput("os_irq_at3", a_irq, 0);
        idle(1);
        expectRead("os_ctr2", 0, 5'h06, 8'h02);
        drainReads();
        checkOutput("os_irq_at2", a_irq, 0);
        idle(1);
        expectRead("os_ctr1", 0, 5'h06, 8'h01);
        drainReads();
        checkOutput("os_irq_at1", a_irq, 0);
        idle(1);
        expectRead("os_ctr0", 0, 5'h06, 8'h00);
        expectRead("os_pend", 0, 5'h04, 8'h01);
        drainReads();
        checkOutput("os_irq_set", a_irq, 1);
        checkOutput("os_irq_pend", a_pend, 2'b01);
        idle(1);
        expectRead("os_ctr_hold", 0, 5'h06, 8'h00);
        drainReads();
        checkOutput("os_irq_stays", a_irq, 1);
        applyStimulus(0, 5'h05, 8'h00);
        expectRead("os_ack_pend", 0, 5'h04, 8'h00);
        expectRead("os_ack_ctr", 0, 5'h06, 8'h00);
        drainReads();
        checkOutput("os_ack_irq", a_irq, 0);

        // Ch1 auto-reload from 2, with ack/set collisions
        applyStimulus(0, 5'h08, 8'h02);
        applyStimulus(0, 5'h09, 8'h00);
        applyStimulus(0, 5'h0B, 8'h03);
        applyStimulus(0, 5'h0C, 8'h01);
        expectRead("ar_req", 0, 5'h0D, 8'h01);
        expectRead("ar_ctr_pre", 0, 5'h0E, 8'h00);
        drainReads();
        idle(1);
        expectRead("ar_ctr_load", 0, 5'h0E, 8'h02);
        expectRead("ar_req_clr", 0, 5'h0D, 8'h00);
        drainReads();
        idle(1);
        expectRead("ar_ctr1", 0, 5'h0E, 8'h01);
        drainReads();
        idle(1);
        expectRead("ar_ctr_rl", 0, 5'h0E, 8'h02);
        expectRead("ar_pend1", 0, 5'h0C, 8'h01);
        drainReads();
        checkOutput("ar_irq_pend", a_pend, 2'b10);
        checkOutput("ar_irq", a_irq, 1);
        applyStimulus(0, 5'h0D, 8'h00);
        expectRead("ar_ack_pend", 0, 5'h0C, 8'h00);
        expectRead("ar_ack_ctr", 0, 5'h0E, 8'h01);
        drainReads();
        applyStimulus(0, 5'h0D, 8'h00);
        expectRead("ar_coll_pend", 0, 5'h0C, 8'h01);
        expectRead("ar_coll_ctr", 0, 5'h0E, 8'h02);
        drainReads();
        applyStimulus(0, 5'h0D, 8'h00);
        expectRead("ar_ack2_pend", 0, 5'h0C, 8'h00);
        drainReads();
        applyStimulus(0, 5'h0B, 8'h00);
        expectRead("ar_ctrlcoll_pend", 0, 5'h0C, 8'h01);
        expectRead("ar_ctrlcoll_ctr", 0, 5'h0E, 8'h02);
        expectRead("ar_ctrl_off", 0, 5'h0B, 8'h00);
        drainReads();
        applyStimulus(0, 5'h0D, 8'h00);
        expectRead("ar_off_pend", 0, 5'h0C, 8'h00);
        expectRead("ar_off_ctr", 0, 5'h0E, 8'h02);
        drainReads();
        checkOutput("ar_quiet", a_pend, 2'b00);

        // Ch0 stop_on_pend freeze
        applyStimulus(0, 5'h00, 8'h02);
        applyStimulus(0, 5'h04, 8'h01);
        applyStimulus(0, 5'h03, 8'h07);
        expectRead("sp_ctr2", 0, 5'h06, 8'h02);
        expectRead("sp_ctrl", 0, 5'h03, 8'h07);
        drainReads();
        idle(1);
        expectRead("sp_ctr1", 0, 5'h06, 8'h01);
        drainReads();
        idle(1);
        expectRead("sp_pend", 0, 5'h04, 8'h01);
        drainReads();
        checkOutput("sp_irq", a_irq, 1);
        idle(10);
        expectRead("sp_frozen_ctr", 0, 5'h06, 8'h02);
        expectRead("sp_frozen_pend", 0, 5'h04, 8'h01);
        drainReads();
        applyStimulus(0, 5'h05, 8'h00);
        expectRead("sp_ack_ctr", 0, 5'h06, 8'h02);
        expectRead("sp_ack_pend", 0, 5'h04, 8'h00);
        drainReads();
        idle(1);
        expectRead("sp_resume", 0, 5'h06, 8'h01);
        drainReads();
        applyStimulus(0, 5'h03, 8'h00);
        expectRead("sp_off_pend", 0, 5'h04, 8'h01);
        expectRead("sp_off_ctr", 0, 5'h06, 8'h02);
        drainReads();
        applyStimulus(0, 5'h05, 8'h00);
        expectRead("sp_off_ack", 0, 5'h04, 8'h00);
        drainReads();

        // Ch1 strobe followed by a reload-byte write loads the old reload
        applyStimulus(0, 5'h08, 8'h10);
        applyStimulus(0, 5'h0C, 8'h01);
        applyStimulus(0, 5'h08, 8'h55);
        expectRead("rc_ctr", 0, 5'h0E, 8'h10);
        expectRead("rc_ctr_hi", 0, 5'h0F, 8'h00);
        expectRead("rc_rld", 0, 5'h08, 8'h55);
        expectRead("rc_req", 0, 5'h0D, 8'h00);
        drainReads();

        // Reset pulse mid-count with irq high
        applyStimulus(0, 5'h03, 8'h01);
        idle(2);
        checkOutput("rm_irq_pre", a_irq, 1);
        #10 map_rst_n = 1'b0;
        #1;
        checkOutput("rm_irq", a_irq, 0);
        checkOutput("rm_irq_pend", a_pend, 2'b00);
        for (int r = 0; r < 8; r++) begin
            expectRead($sformatf("rm_ch0_r%0d", r), 0, 5'(r), (r == 2) ? 8'hFF : 8'h00);
        end
        expectRead("rm_ch1_rld", 0, 5'h08, 8'h00);
        expectRead("rm_ch1_ctr", 0, 5'h0E, 8'h00);
        expectRead("rm_absent0", 0, 5'h10, 8'hFF);
        expectRead("rm_absent3", 0, 5'h1B, 8'hFF);
        drainReads();
        #5 map_rst_n = 1'b1;
        @(posedge m2);
        applyStimulus(0, 5'h00, 8'h05);
        applyStimulus(0, 5'h04, 8'h01);
        idle(3);
        expectRead("rm_nocount", 0, 5'h06, 8'h05);
        expectRead("rm_nopend", 0, 5'h04, 8'h00);
        drainReads();

        // CH=1, W=24 instance
        applyStimulus(1, 5'h0B, 8'h01);
        applyStimulus(1, 5'h08, 8'h07);
        expectRead("pw_absent_ctrl", 1, 5'h0B, 8'hFF);
        expectRead("pw_absent_rld", 1, 5'h08, 8'hFF);
        drainReads();
        applyStimulus(1, 5'h02, 8'h01);
        applyStimulus(1, 5'h04, 8'h01);
        idle(1);
        expectRead("pw_ctr_lo", 1, 5'h06, 8'h00);
        expectRead("pw_ctr_hi", 1, 5'h07, 8'h00);
        expectRead("pw_rld2", 1, 5'h02, 8'h01);
        expectRead("pw_rld0", 1, 5'h00, 8'h00);
        drainReads();
        applyStimulus(1, 5'h03, 8'h01);
        expectRead("pw_en_nocount", 1, 5'h06, 8'h00);
        drainReads();
        idle(1);
        expectRead("pw_dec_lo", 1, 5'h06, 8'hFF);
        expectRead("pw_dec_hi", 1, 5'h07, 8'hFF);
        expectRead("pw_dec_pend", 1, 5'h04, 8'h00);
        drainReads();
        checkOutput("pw_irq", b_irq, 0);
        idle(1);
        expectRead("pw_dec2_lo", 1, 5'h06, 8'hFE);
        drainReads();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
